div_unit: RTL and testbench



---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step.sv | 26 ++
 rtl/div_unit.sv | 117 +++++++++++
 tb/tb_div_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings and constants for the multi-cycle divide unit.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam int          DIV_ITER      = 32;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: produces the next partial remainder
// and shifts one quotient bit into the dividend register.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_nxt,
  output logic [WIDTH-1:0] dvd_nxt
);

  logic [WIDTH:0]        shifted;
  logic signed [WIDTH:0] trial;
  logic                  take;

  always_comb begin
    shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    trial   = $signed(shifted - {1'b0, dvs});
    // A set top remainder bit would mean the shifted value already exceeds any divisor.
    take    = rem[WIDTH] | ~trial[WIDTH];
    rem_nxt = take ? $unsigned(trial) : shifted;
    dvd_nxt = {dvd[WIDTH-2:0], take};
  end

endmodule

// File: rtl/div_unit.sv
// 32-bit signed/unsigned divide and remainder unit, one quotient bit per cycle,
// with start/busy/done handshake and early exit for divide-by-zero and overflow.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_A,
  input  logic [WIDTH-1:0] op_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  div_state_e       state, state_nxt;
  div_op_e          op_q;
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] dvd, dvs, dvd_nxt;
  logic [WIDTH:0]   rem, rem_nxt;
  logic [5:0]       cnt;

  logic             accept, is_signed, by_zero, overflow, special, last;
  logic [WIDTH-1:0] abs_a, abs_b, special_res, q_fix, r_fix;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    accept      = start && (state != CALC);
    is_signed   = ~op[0];
    by_zero     = (op_B == '0);
    overflow    = is_signed && (op_A == WIDTH'(INT_MIN)) && (op_B == '1);
    special     = by_zero || overflow;
    abs_a       = cond_neg(op_A, is_signed && op_A[WIDTH-1]);
    abs_b       = cond_neg(op_B, is_signed && op_B[WIDTH-1]);
    special_res = by_zero ? (op[1] ? op_A : WIDTH'(DIV_BY_ZERO_Q))
                          : (op[1] ? '0   : WIDTH'(INT_MIN));
    last        = (cnt == 6'(DIV_ITER - 1));
    q_fix       = cond_neg(dvd_nxt, q_neg);
    r_fix       = cond_neg(rem_nxt[WIDTH-1:0], r_neg);
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd     (dvd),
    .dvs     (dvs),
    .rem_nxt (rem_nxt),
    .dvd_nxt (dvd_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: ;
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (accept) state_nxt = special ? DONE : CALC;
  end

  // Control and visible outputs: counter, result and div_zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      result   <= '0;
      div_zero <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      if (special) begin
        result   <= special_res;
        div_zero <= by_zero;
      end
    end else if (state == CALC) begin
      cnt <= cnt + 6'd1;
      if (last) begin
        result   <= ((op_q == OP_REM) || (op_q == OP_REMU)) ? r_fix : q_fix;
        div_zero <= 1'b0;
      end
    end
  end

  // Iteration datapath: operand magnitudes, shifting quotient and partial remainder
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= div_op_e'(op);
      q_neg <= is_signed && (op_A[WIDTH-1] ^ op_B[WIDTH-1]);
      r_neg <= is_signed && op_A[WIDTH-1];
      dvd   <= abs_a;
      dvs   <= abs_b;
      rem   <= '0;
    end else if (state == CALC) begin
      dvd <= dvd_nxt;
      rem <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, special cases,
// handshake timing, ignored start, back-to-back accept and mid-operation reset.
module tb_div_unit;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [1:0]  op;
  logic [31:0] op_A, op_B;
  logic        busy, done;
  logic [31:0] result;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .op_A     (op_A),
    .op_B     (op_B),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  // Issue one operation and observe it; k counts cycles after the accept edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_k, output logic [31:0] res, output logic dz,
                        output int lat, output int busy_cnt, output int done_cnt,
                        output int overlap);
    res = '0; dz = 1'b0; lat = 0; busy_cnt = 0; done_cnt = 0; overlap = 0;
    op = o; op_A = a; op_B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op_A = 32'hDEAD_BEEF; op_B = 32'h1;
    for (int k = 1; k <= 40; k++) begin
      start = (k == poke_k);
      if (k == poke_k) begin op = REMU; op_A = 32'd50; op_B = 32'd5; end
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (done) begin
        done_cnt++;
        if (lat == 0) begin lat = k; res = result; dz = div_zero; end
      end
      if (lat != 0 && k >= lat + 2) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = DIV; op_A = '0; op_B = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [31:0] res; logic dz; int lat, bc, dc, ov;
    run_op(DIVU, 32'd100, 32'd7, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h want %h", res, 32'd14); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", lat); end
    checks++; if (bc !== 32) begin errors++; $display("FAIL divu_busy_cycles: got %0d want 32", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL divu_done_pulses: got %0d want 1", dc); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL divu_busy_done_overlap: got %0d want 0", ov); end
    checks++; if (result !== 32'd14) begin errors++; $display("FAIL divu_hold: got %h want %h", result, 32'd14); end
    run_op(REMU, 32'd100, 32'd7, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h want %h", res, 32'd2); end
    checks++; if (lat !== 33 || dc !== 1) begin errors++; $display("FAIL remu_timing: got lat %0d pulses %0d want 33/1", lat, dc); end
    run_op(DIVU, 32'hFFFF_FF9C, 32'd7, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'h2492_4916) begin errors++; $display("FAIL divu_big: got %h want %h", res, 32'h2492_4916); end
    run_op(DIVU, 32'hFFFF_FFFF, 32'd1, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max_by_1: got %h want ffffffff", res); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL divu_max_div_zero: got %b want 0", dz); end
  endtask

  task automatic test_signed();
    logic [31:0] res; logic dz; int lat, bc, dc, ov;
    run_op(DIV, 32'hFFFF_FF9C, 32'd7, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_m100_7: got %h want fffffff2", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
    run_op(REM, 32'hFFFF_FF9C, 32'd7, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL rem_m100_7: got %h want fffffffe", res); end
    run_op(REM, 32'd100, 32'hFFFF_FFF9, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL rem_100_m7: got %h want 00000002", res); end
    run_op(DIV, 32'd100, 32'hFFFF_FFF9, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'hFFFF_FFF2) begin errors++; $display("FAIL div_100_m7: got %h want fffffff2", res); end
  endtask

  task automatic test_special();
    logic [31:0] res; logic dz; int lat, bc, dc, ov;
    run_op(DIV, 32'd5, 32'd0, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero_q: got %h want ffffffff", res); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL div_by_zero_flag: got %b want 1", dz); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_by_zero_latency: got %0d want 1", lat); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL div_by_zero_busy: got %0d busy cycles want 0", bc); end
    run_op(REM, 32'd5, 32'd0, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL rem_by_zero: got %h want 00000005", res); end
    checks++; if (dz !== 1'b1 || lat !== 1 || bc !== 0) begin errors++; $display("FAIL rem_by_zero_timing: got dz %b lat %0d busy %0d want 1/1/0", dz, lat, bc); end
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL div_overflow: got %h want 80000000", res); end
    checks++; if (dz !== 1'b0 || lat !== 1 || bc !== 0) begin errors++; $display("FAIL div_overflow_timing: got dz %b lat %0d busy %0d want 0/1/0", dz, lat, bc); end
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'h0) begin errors++; $display("FAIL rem_overflow: got %h want 00000000", res); end
  endtask

  task automatic test_ignored_start();
    logic [31:0] res; logic dz; int lat, bc, dc, ov;
    run_op(DIVU, 32'd100, 32'd7, 10, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL ignored_start_result: got %h want %h", res, 32'd14); end
    checks++; if (lat !== 33 || dc !== 1) begin errors++; $display("FAIL ignored_start_timing: got lat %0d pulses %0d want 33/1", lat, dc); end
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    logic [31:0] r1, r2;
    k1 = 0; k2 = 0; r1 = '0; r2 = '0;
    op = DIVU; op_A = 32'd100; op_B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (done) begin k1 = k; r1 = result; break; end
      @(posedge clk); #1;
    end
    op = DIVU; op_A = 32'd1000; op_B = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_accept: got busy %b done %b want 1/0", busy, done); end
    for (int k = 1; k <= 40; k++) begin
      if (done) begin k2 = k; r2 = result; break; end
      @(posedge clk); #1;
    end
    checks++; if (k1 !== 33 || r1 !== 32'd14) begin errors++; $display("FAIL b2b_first: got lat %0d res %h want 33/%h", k1, r1, 32'd14); end
    checks++; if (k2 !== 33) begin errors++; $display("FAIL b2b_second_latency: got %0d want 33", k2); end
    checks++; if (r2 !== 32'd100) begin errors++; $display("FAIL b2b_second_result: got %h want %h", r2, 32'd100); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    logic [31:0] res; logic dz; int lat, bc, dc, ov;
    op = DIVU; op_A = 32'd100; op_B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_ctrl: got busy %b done %b want 0/0", busy, done); end
    checks++; if (result !== 32'h0 || div_zero !== 1'b0) begin errors++; $display("FAIL mid_reset_outputs: got %h/%b want 0/0", result, div_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_idle: got busy %b done %b want 0/0", busy, done); end
    run_op(DIVU, 32'd9, 32'd3, 0, res, dz, lat, bc, dc, ov);
    checks++; if (res !== 32'd3 || lat !== 33) begin errors++; $display("FAIL post_reset_divu: got %h lat %0d want 00000003/33", res, lat); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_special();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
